// File: rtl/pudding_pkg.sv
// Shared types and constants for the PUDDING DAC loader.
package pudding_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StXfer  = 2'd2,
        StDwell = 2'd3
    } loader_state_e;

    // Default number of unit cells (and daisychain length).
    localparam int unsigned N_CELLS_DEFAULT = 128;

    // Bit positions of the DAC core controls within ui_in.
    localparam int unsigned UI_DATUM    = 0;
    localparam int unsigned UI_SHIFT    = 1;
    localparam int unsigned UI_TRANSFER = 2;
    localparam int unsigned UI_DIR      = 3;
    localparam int unsigned UI_STATEEN  = 4;
    localparam int unsigned UI_CTRL_W   = 5;

endpackage

// File: rtl/pudding_dac_loader.sv
// Serialises a requested DAC level into the PUDDING daisychain, commits it to the
// core state register and then enforces a programmable dwell before the next update.
module pudding_dac_loader
    import pudding_pkg::*;
#(
    parameter int unsigned N_CELLS = N_CELLS_DEFAULT,
    parameter int unsigned CODE_W  = 8,
    parameter int unsigned HOLD_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_code,
    input  logic [HOLD_W-1:0] req_hold,
    input  logic              en_req,
    output logic              datum,
    output logic              shift,
    output logic              transfer,
    output logic              dir,
    output logic              dac_en,
    output logic              done,
    output logic              sat,
    output logic              busy
);

    localparam int unsigned CNT_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_CELLS - 1);
    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(N_CELLS);
    localparam logic [CODE_W:0]   CELLS_X  = (CODE_W + 1)'(N_CELLS);

    loader_state_e     state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              committed_q, committed_d;
    logic              sat_q, sat_d;

    logic req_ready_q, req_ready_d;
    logic datum_q, datum_d;
    logic shift_q, shift_d;
    logic transfer_q, transfer_d;
    logic dir_q, dir_d;
    logic dac_en_q, dac_en_d;
    logic done_q, done_d;
    logic busy_q, busy_d;

    logic [CODE_W:0] zero_cnt;

    // Next-state logic; outputs are derived from the next state so the registered
    // pins line up with the FSM state they describe.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        sat_d       = sat_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    if (req_code > CODE_MAX) begin
                        code_d = CODE_MAX;
                        sat_d  = 1'b1;
                    end else begin
                        code_d = req_code;
                    end
                    hold_d  = req_hold;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StXfer: begin
                committed_d = 1'b1;
                state_d     = (hold_q != '0) ? StDwell : StIdle;
            end
            StDwell: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Zeros go in first, so the last code_d shifts carry ones.
        zero_cnt    = CELLS_X - {1'b0, code_d};
        req_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        shift_d     = (state_d == StShift);
        datum_d     = shift_d && ((CODE_W + 1)'(cnt_d) >= zero_cnt);
        transfer_d  = (state_d == StXfer);
        dir_d       = 1'b1;
        done_d      = (state_q == StXfer);
        // Using committed_d lets the enable rise the cycle right after the first commit.
        dac_en_d    = en_req && committed_d;
    end

    // State and output registers; reset forces IDLE with every output low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            code_q      <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            sat_q       <= 1'b0;
            req_ready_q <= 1'b0;
            datum_q     <= 1'b0;
            shift_q     <= 1'b0;
            transfer_q  <= 1'b0;
            dir_q       <= 1'b0;
            dac_en_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            sat_q       <= sat_d;
            req_ready_q <= req_ready_d;
            datum_q     <= datum_d;
            shift_q     <= shift_d;
            transfer_q  <= transfer_d;
            dir_q       <= dir_d;
            dac_en_q    <= dac_en_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign datum     = datum_q;
    assign shift     = shift_q;
    assign transfer  = transfer_q;
    assign dir       = dir_q;
    assign dac_en    = dac_en_q;
    assign done      = done_q;
    assign sat       = sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pudding_dac_loader.sv
// Scoreboard bench for pudding_dac_loader with a behavioural model of the DAC core.
module tb_pudding_dac_loader;
    import pudding_pkg::*;

    localparam int unsigned N  = 128;
    localparam int unsigned CW = 8;
    localparam int unsigned HW = 16;
    localparam int BUDGET = 600;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_por;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_code;
    logic [HW-1:0] req_hold;
    logic          en_req;
    logic          datum, shift, transfer, dir, dac_en, done, sat, busy;

    logic [UI_CTRL_W-1:0] ui;
    logic [N-1:0]         chain;
    logic [N-1:0]         core_state;

    typedef struct {
        logic [N-1:0] state;
        logic         sat;
        int unsigned  code;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Monitor state.
    int unsigned shifts = 0, ones = 0, xfers = 0;
    bit order_bad = 0, ready_busy = 0, en_early = 0, en_next = 0, first_xfer = 0;

    pudding_dac_loader #(
        .N_CELLS (N),
        .CODE_W  (CW),
        .HOLD_W  (HW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_hold  (req_hold),
        .en_req    (en_req),
        .datum     (datum),
        .shift     (shift),
        .transfer  (transfer),
        .dir       (dir),
        .dac_en    (dac_en),
        .done      (done),
        .sat       (sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    assign ui[UI_DATUM]    = datum;
    assign ui[UI_SHIFT]    = shift;
    assign ui[UI_TRANSFER] = transfer;
    assign ui[UI_DIR]      = dir;
    assign ui[UI_STATEEN]  = dac_en;

    // DAC core model: new bits enter at index 0; transfer with dir=1 commits the chain.
    always @(posedge clk) begin
        if (core_por) begin
            chain      <= '0;
            core_state <= '0;
        end else begin
            if (ui[UI_SHIFT]) chain <= {chain[N-2:0], ui[UI_DATUM]};
            if (ui[UI_TRANSFER] && ui[UI_DIR]) core_state <= chain;
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts serial traffic and checks each commit when done pulses.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            shifts = 0;
            ones = 0;
            order_bad = 0;
            en_next = 0;
        end else begin
            if (busy && req_ready) ready_busy = 1;
            if (en_next) begin
                check("dac_en cycle after first xfer", dac_en, 1);
                en_next = 0;
            end
            if (!first_xfer && dac_en) en_early = 1;
            if (shift) begin
                shifts++;
                if (datum) ones++;
                else if (ones != 0) order_bad = 1;
            end
            if (transfer) begin
                xfers++;
                check("xfer {dir,shift,datum}", {dir, shift, datum}, 3'b100);
                if (!first_xfer) begin
                    first_xfer = 1;
                    en_next = 1;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("pending requests at done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("core state", core_state, e.state);
                    check("sat at done", sat, e.sat);
                    check("shift pulses", shifts, N);
                    check("datum ones", ones, e.code);
                    check("zeros before ones", order_bad, 0);
                    // Done occupies the cycle after the edge at accept+N+1.
                    check("done latency", cyc - e.acc, N + 1);
                end
                shifts = 0;
                ones = 0;
                order_bad = 0;
            end
        end
    end

    // Called at a negedge: presents a request, pushes its expectation at accept.
    task automatic send(input int unsigned code, input int unsigned hold,
                        input logic [N-1:0] exp_state, input logic exp_sat, output int acc);
        int n = 0;
        exp_t e;
        acc = 0;
        req_valid = 1'b1;
        req_code  = CW'(code);
        req_hold  = HW'(hold);
        while (!req_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("request accepted in budget", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        e.state = exp_state;
        e.sat   = exp_sat;
        e.code  = (code > N) ? N : code;
        e.acc   = cyc + 1;
        acc     = e.acc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", sb.size(), 0);
    endtask

    task automatic run(input int unsigned code, input int unsigned hold,
                       input logic [N-1:0] exp_state, input logic exp_sat);
        int a;
        send(code, hold, exp_state, exp_sat, a);
        req_valid = 1'b0;
        drain();
    endtask

    initial begin
        int a0, a1, n, xf;
        rst = 1'b1;
        core_por = 1'b1;
        req_valid = 1'b0;
        req_code = '0;
        req_hold = '0;
        en_req = 1'b1;
        repeat (3) @(negedge clk);
        check("outputs in reset",
              {req_ready, datum, shift, transfer, dir, dac_en, done, sat, busy}, 0);
        rst = 1'b0;
        core_por = 1'b0;
        @(negedge clk);
        check("req_ready after reset", req_ready, 1);
        check("dir after reset", dir, 1);

        run(5, 0, 128'h1F, 1'b0);
        run(0, 0, 128'h0, 1'b0);
        run(128, 0, {N{1'b1}}, 1'b0);
        run(200, 0, {N{1'b1}}, 1'b1);
        run(3, 0, 128'h7, 1'b1);

        // Back-to-back with req_valid held high.
        send(7, 10, 128'h7F, 1'b1, a0);
        send(9, 10, 128'h1FF, 1'b1, a1);
        req_valid = 1'b0;
        check("accept spacing hold=10", a1 - a0, N + 12);
        drain();
        send(1, 0, 128'h1, 1'b1, a0);
        send(2, 0, 128'h3, 1'b1, a1);
        req_valid = 1'b0;
        check("accept spacing hold=0", a1 - a0, N + 2);
        drain();
        check("req_ready low while busy", ready_busy, 0);

        // Reset in the middle of the shift window.
        send(20, 0, 128'hFFFFF, 1'b1, a0);
        req_valid = 1'b0;
        n = 0;
        while (shifts < 60 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        xf = xfers;
        #2 rst = 1'b1;
        #1 check("outputs after mid-shift reset",
                 {req_ready, datum, shift, transfer, dir, dac_en, done, sat, busy}, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("no transfer after reset", xfers, xf);
        check("core state kept", core_state, 128'h3);
        run(4, 0, 128'hF, 1'b0);

        // Enable follows en_req one cycle later once committed.
        check("dac_en with en_req high", dac_en, 1);
        en_req = 1'b0;
        @(negedge clk);
        check("dac_en after en_req drop", dac_en, 0);
        check("dac_en before first xfer", en_early, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
